// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared types and constants for the subtractive GCD controller.
//   gcd_state_t : controller state encoding
//   in_sel_t    : register-file data_in mux select (X, Y, subtractor result)
//   REG_*       : register-file map (reg0 = A working, reg1 = B working,
//                 reg2 = result, reg3 unused)
// -----------------------------------------------------------------------------
package gcd_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD_X = 4'd1,
      S_LOAD_Y = 4'd2,
      S_CMP    = 4'd3,
      S_SUB_A  = 4'd4,
      S_SUB_B  = 4'd5,
      S_ST_A   = 4'd6,
      S_ST_B   = 4'd7,
      S_DONE   = 4'd8
   } gcd_state_t;

   typedef enum logic [1:0] {
      SEL_X    = 2'd0,
      SEL_Y    = 2'd1,
      SEL_DIFF = 2'd2
   } in_sel_t;

   localparam logic [1:0] REG_A   = 2'd0;
   localparam logic [1:0] REG_B   = 2'd1;
   localparam logic [1:0] REG_RES = 2'd2;

   // Zero-extend a 2-bit register index onto the 3-bit write-address bus.
   function automatic logic [2:0] to_wa(input logic [1:0] idx);
      return {1'b0, idx};
   endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// -----------------------------------------------------------------------------
// gcd_iter_cnt
// Saturating up-counter for the number of subtraction steps in a GCD run.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high; clears the count
//   clr    in   1      synchronous clear (start of a new run)
//   inc    in   1      add one, sticking at 2**CNT_W-1
//   count  out  CNT_W  current count
// -----------------------------------------------------------------------------
module gcd_iter_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/gcd_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_ctrl
// Moore control FSM for an 8-bit subtractive GCD datapath built around a 4x8
// register file (reg0 = A, reg1 = B, reg2 = result). Loads X and Y, then
// repeatedly replaces the larger operand by the difference until one operand
// is zero or both are equal, stores the answer in reg2 and pulses done.
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   start       in   1      run request, sampled only in IDLE
//   a_zero      in   1      rf A output == 0      (used only in CMP)
//   b_zero      in   1      rf B output == 0      (used only in CMP)
//   a_eq_b      in   1      rf A == rf B          (used only in CMP)
//   a_lt_b      in   1      rf A <  rf B unsigned (used only in CMP)
//   we          out  1      rf write enable
//   wa          out  3      rf write address (bit 2 always 0)
//   rae/raa     out  1/2    rf read port A enable/address
//   rbe/rba     out  1/2    rf read port B enable/address
//   in_sel      out  2      data_in mux: 0=X, 1=Y, 2=DIFF
//   sub_op      out  1      subtractor direction: 0=A-B, 1=B-A
//   busy        out  1      high except in IDLE and DONE
//   done        out  1      one-cycle pulse, result valid in reg2
//   iter_count  out  CNT_W  subtraction count of the last/current run
//
// Configuration macro: GCD_ITER_COUNT_EN
//   defined   : iter_count is a saturating count of SUB_A/SUB_B cycles,
//               cleared in LOAD_X and held through DONE/IDLE.
//   undefined : iter_count is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             a_zero,
   input  logic             b_zero,
   input  logic             a_eq_b,
   input  logic             a_lt_b,
   output logic             we,
   output logic [2:0]       wa,
   output logic             rae,
   output logic [1:0]       raa,
   output logic             rbe,
   output logic [1:0]       rba,
   output logic [1:0]       in_sel,
   output logic             sub_op,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter_count
);

   gcd_state_t state;
   gcd_state_t state_nxt;
   in_sel_t    sel;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Comparator flags are consulted only in CMP; in every
   // other state the sequence is fixed.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_LOAD_X;
         S_LOAD_X: state_nxt = S_LOAD_Y;
         S_LOAD_Y: state_nxt = S_CMP;
         S_CMP: begin
            if (a_zero)                state_nxt = S_ST_B;
            else if (b_zero || a_eq_b) state_nxt = S_ST_A;
            else if (a_lt_b)           state_nxt = S_SUB_B;
            else                       state_nxt = S_SUB_A;
         end
         S_SUB_A:  state_nxt = S_CMP;
         S_SUB_B:  state_nxt = S_CMP;
         S_ST_A:   state_nxt = S_DONE;
         S_ST_B:   state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the registered state only.
   always_comb begin
      we     = 1'b0;
      wa     = 3'd0;
      rae    = 1'b0;
      raa    = 2'd0;
      rbe    = 1'b0;
      rba    = 2'd0;
      sel    = SEL_X;
      sub_op = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      unique case (state)
         S_IDLE: begin
            // Keep the result register visible on port A between runs.
            busy = 1'b0;
            rae  = 1'b1;
            raa  = REG_RES;
         end
         S_LOAD_X: begin
            we  = 1'b1;
            wa  = to_wa(REG_A);
            sel = SEL_X;
         end
         S_LOAD_Y: begin
            we  = 1'b1;
            wa  = to_wa(REG_B);
            sel = SEL_Y;
         end
         S_CMP: begin
            rae = 1'b1;
            raa = REG_A;
            rbe = 1'b1;
            rba = REG_B;
         end
         S_SUB_A: begin
            we     = 1'b1;
            wa     = to_wa(REG_A);
            sel    = SEL_DIFF;
            sub_op = 1'b0;
            rae    = 1'b1;
            raa    = REG_A;
            rbe    = 1'b1;
            rba    = REG_B;
         end
         S_SUB_B: begin
            we     = 1'b1;
            wa     = to_wa(REG_B);
            sel    = SEL_DIFF;
            sub_op = 1'b1;
            rae    = 1'b1;
            raa    = REG_A;
            rbe    = 1'b1;
            rba    = REG_B;
         end
         // Final store: only the surviving operand's port is enabled, so the
         // datapath's DIFF path passes that port straight through to reg2.
         S_ST_A: begin
            we  = 1'b1;
            wa  = to_wa(REG_RES);
            sel = SEL_DIFF;
            rae = 1'b1;
            raa = REG_A;
         end
         S_ST_B: begin
            we  = 1'b1;
            wa  = to_wa(REG_RES);
            sel = SEL_DIFF;
            rbe = 1'b1;
            rba = REG_B;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            rae  = 1'b1;
            raa  = REG_RES;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign in_sel = sel;

`ifdef GCD_ITER_COUNT_EN
   logic cnt_clr;
   logic cnt_inc;

   // Clearing in LOAD_X (rather than on start) keeps the previous run's
   // count visible through DONE and IDLE.
   assign cnt_clr = (state == S_LOAD_X);
   assign cnt_inc = (state == S_SUB_A) || (state == S_SUB_B);

   gcd_iter_cnt #(
      .CNT_W(CNT_W)
   ) u_iter_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .count(iter_count)
   );
`else
   assign iter_count = '0;
`endif

endmodule

// File: tb/tb_gcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcd_ctrl
// Bench for gcd_ctrl. A behavioural 4x8 register file, subtractor and
// comparator close the loop around the controller. A second controller with
// CNT_W=4 shares the same flags to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_gcd_ctrl;

   localparam int ST_IDLE  = 0;
   localparam int ST_LDX   = 1;
   localparam int ST_LDY   = 2;
   localparam int ST_CMP   = 3;
   localparam int ST_SUBA  = 4;
   localparam int ST_SUBB  = 5;
   localparam int ST_STA   = 6;
   localparam int ST_STB   = 7;
   localparam int ST_DONE  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start;
   logic       a_zero, b_zero, a_eq_b, a_lt_b;
   logic       we, rae, rbe, sub_op, busy, done;
   logic [2:0] wa;
   logic [1:0] raa, rba, in_sel;
   logic [7:0] iter_count;

   logic       we_4, rae_4, rbe_4, sub_op_4, busy_4, done_4;
   logic [2:0] wa_4;
   logic [1:0] raa_4, rba_4, in_sel_4;
   logic [3:0] iter_count_4;

   logic [7:0] x_val, y_val;
   logic [7:0] rf [4] = '{default: 8'd0};
   logic [7:0] pa, pb, wdata;

   int total = 0;
   int bad   = 0;

   gcd_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_zero(a_zero), .b_zero(b_zero), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
      .we(we), .wa(wa), .rae(rae), .raa(raa), .rbe(rbe), .rba(rba),
      .in_sel(in_sel), .sub_op(sub_op), .busy(busy), .done(done),
      .iter_count(iter_count)
   );

   gcd_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start),
      .a_zero(a_zero), .b_zero(b_zero), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
      .we(we_4), .wa(wa_4), .rae(rae_4), .raa(raa_4), .rbe(rbe_4), .rba(rba_4),
      .in_sel(in_sel_4), .sub_op(sub_op_4), .busy(busy_4), .done(done_4),
      .iter_count(iter_count_4)
   );

   // Datapath model: disabled read ports read as zero; DIFF subtracts when
   // both ports are enabled, otherwise passes the enabled port.
   always_comb begin
      pa     = rae ? rf[raa] : 8'd0;
      pb     = rbe ? rf[rba] : 8'd0;
      a_zero = (pa == 8'd0);
      b_zero = (pb == 8'd0);
      a_eq_b = (pa == pb);
      a_lt_b = (pa < pb);
      wdata  = 8'd0;
      case (in_sel)
         2'd0: wdata = x_val;
         2'd1: wdata = y_val;
         2'd2: wdata = (rae && rbe) ? (sub_op ? pb - pa : pa - pb) : (pa | pb);
         default: wdata = 8'd0;
      endcase
   end

   always @(posedge clk) begin
      if (we) rf[wa[1:0]] <= wdata;
   end

   logic [14:0] sig, sig4;
   assign sig  = {we, wa, in_sel, sub_op, busy, done, rae, raa, rbe, rba};
   assign sig4 = {we_4, wa_4, in_sel_4, sub_op_4, busy_4, done_4, rae_4, raa_4, rbe_4, rba_4};

   // Expected output pattern per state:
   //            we  wa    in_sel sub  busy done rae raa   rbe rba
   function automatic logic [14:0] exp_sig(input int st);
      case (st)
         ST_IDLE: return {1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0};
         ST_LDX:  return {1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
         ST_LDY:  return {1'b1, 3'd1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
         ST_CMP:  return {1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1};
         ST_SUBA: return {1'b1, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1};
         ST_SUBB: return {1'b1, 3'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1};
         ST_STA:  return {1'b1, 3'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0};
         ST_STB:  return {1'b1, 3'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1};
         ST_DONE: return {1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0};
         default: return 15'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and land on the falling edge for sampling/driving.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Start a run; returns the cycle (relative to the start cycle) where done
   // is first seen, or -1 if it never appears. Leaves the bench in DONE.
   task automatic run_gcd(input logic [7:0] x, input logic [7:0] y, output int dcyc);
      x_val = x;
      y_val = y;
      start = 1'b1;
      tick;
      start = 1'b0;
      dcyc  = -1;
      for (int c = 1; c <= 600; c++) begin
         if (done) begin
            dcyc = c;
            break;
         end
         tick;
      end
   endtask

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] res;
      int         cyc;
      int         it;
      int         it4;
   } vec_t;

   vec_t vecs [7];
   int   seq  [10];

   initial begin
      int dcyc;
      int ndone;
      int dlist [4];
      logic [7:0] exp_it;
      logic [3:0] exp_it4;

      vecs[0] = '{x: 8'd12,  y: 8'd8,  res: 8'd4, cyc: 9,   it: 2,   it4: 2};
      vecs[1] = '{x: 8'd0,   y: 8'd9,  res: 8'd9, cyc: 5,   it: 0,   it4: 0};
      vecs[2] = '{x: 8'd255, y: 8'd1,  res: 8'd1, cyc: 513, it: 254, it4: 15};
      vecs[3] = '{x: 8'd9,   y: 8'd0,  res: 8'd9, cyc: 5,   it: 0,   it4: 0};
      vecs[4] = '{x: 8'd0,   y: 8'd0,  res: 8'd0, cyc: 5,   it: 0,   it4: 0};
      vecs[5] = '{x: 8'd7,   y: 8'd7,  res: 8'd7, cyc: 5,   it: 0,   it4: 0};
      vecs[6] = '{x: 8'd21,  y: 8'd6,  res: 8'd3, cyc: 13,  it: 4,   it4: 4};

      seq = '{ST_LDX, ST_LDY, ST_CMP, ST_SUBA, ST_CMP, ST_SUBB, ST_CMP, ST_STA, ST_DONE, ST_IDLE};

      reset = 1'b1;
      start = 1'b0;
      x_val = 8'd0;
      y_val = 8'd0;
      @(negedge clk);
      tick;
      tick;
      chk("reset_sig", {17'd0, sig}, {17'd0, exp_sig(ST_IDLE)});
      chk("reset_iter", {24'd0, iter_count}, 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_sig", {17'd0, sig}, {17'd0, exp_sig(ST_IDLE)});

      // Cycle-by-cycle state sequence for 12,8.
      x_val = 8'd12;
      y_val = 8'd8;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("seq_c%0d", c + 1), {17'd0, sig}, {17'd0, exp_sig(seq[c])});
         chk($sformatf("seq4_c%0d", c + 1), {17'd0, sig4}, {17'd0, exp_sig(seq[c])});
         tick;
      end

      // Table-driven runs.
      for (int i = 0; i < 7; i++) begin
`ifdef GCD_ITER_COUNT_EN
         exp_it  = 8'(vecs[i].it);
         exp_it4 = 4'(vecs[i].it4);
`else
         exp_it  = 8'd0;
         exp_it4 = 4'd0;
`endif
         run_gcd(vecs[i].x, vecs[i].y, dcyc);
         chk($sformatf("v%0d_cycles", i), dcyc, vecs[i].cyc);
         chk($sformatf("v%0d_result", i), {24'd0, rf[2]}, {24'd0, vecs[i].res});
         chk($sformatf("v%0d_iter", i), {24'd0, iter_count}, {24'd0, exp_it});
         chk($sformatf("v%0d_iter4", i), {28'd0, iter_count_4}, {28'd0, exp_it4});
         tick;
         chk($sformatf("v%0d_idle", i), {17'd0, sig}, {17'd0, exp_sig(ST_IDLE)});
         chk($sformatf("v%0d_iter_hold", i), {24'd0, iter_count}, {24'd0, exp_it});
         if (dcyc < 0) begin
            reset = 1'b1;
            tick;
            reset = 1'b0;
         end
      end

      // start re-pulsed while busy and in DONE: only one done expected.
      x_val = 8'd12;
      y_val = 8'd8;
      start = 1'b1;
      tick;
      start = 1'b0;
      ndone = 0;
      dcyc  = -1;
      for (int c = 1; c <= 25; c++) begin
         if (done) begin
            ndone++;
            if (dcyc < 0) dcyc = c;
         end
         start = (c == 3 || c == 6 || c == 9);
         tick;
      end
      start = 1'b0;
      chk("repulse_ndone", ndone, 1);
      chk("repulse_cycle", dcyc, 9);
      chk("repulse_result", {24'd0, rf[2]}, 32'd4);

      // start held high: back-to-back runs, one done each.
      start = 1'b1;
      tick;
      ndone = 0;
      for (int c = 1; c <= 30; c++) begin
         if (done) begin
            if (ndone < 4) dlist[ndone] = c;
            ndone++;
         end
         if (c == 19) start = 1'b0;
         tick;
      end
      chk("held_ndone", ndone, 2);
      chk("held_first", dlist[0], 9);
      chk("held_second", dlist[1], 19);
      chk("held_result", {24'd0, rf[2]}, 32'd4);

      // Reset during the third subtraction of 200,3.
      x_val = 8'd200;
      y_val = 8'd3;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c < 8; c++) tick;
      chk("mid_sub3_sig", {17'd0, sig}, {17'd0, exp_sig(ST_SUBA)});
      reset = 1'b1;
      tick;
      chk("mid_reset_sig", {17'd0, sig}, {17'd0, exp_sig(ST_IDLE)});
      chk("mid_reset_iter", {24'd0, iter_count}, 32'd0);
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (done || busy) ndone++;
         tick;
      end
      chk("mid_no_done", ndone, 0);
      chk("mid_idle_sig", {17'd0, sig}, {17'd0, exp_sig(ST_IDLE)});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
